mult_rr_arbiter: RTL and testbench

//  Shares one START/END_MULT handshake multiplier (multipli_parallel or its sequential successor)

---
 rtl/mult_rr_arbiter_if.sv | 44 ++++
 rtl/mult_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mult_rr_arbiter_if
//   Bundles both sides of mult_rr_arbiter: the NREQ client request/result
//   signals and the START/END_MULT handshake towards one shared multiplier.
//   Parameters must match the arbiter instance that binds to it.
//
//   Client side : REQ, A_BUS, B_BUS (to arbiter); GNT, DONE, RESULT, ERR,
//                 BUSY (from arbiter)
//   Multiplier  : M_START, M_A, M_B (from arbiter); M_S, M_END (to arbiter)
//
//   Modports
//     slave  : the arbiter itself
//     master : the environment (clients plus multiplier)
// ----------------------------------------------------------------------------
interface mult_rr_arbiter_if #(
  parameter int tamano = 8,
  parameter int NREQ   = 4
) ();

  logic [NREQ-1:0]        REQ;
  logic [NREQ*tamano-1:0] A_BUS;
  logic [NREQ*tamano-1:0] B_BUS;
  logic [NREQ-1:0]        GNT;
  logic [NREQ-1:0]        DONE;
  logic [2*tamano-1:0]    RESULT;
  logic                   ERR;
  logic                   BUSY;
  logic                   M_START;
  logic [tamano-1:0]      M_A;
  logic [tamano-1:0]      M_B;
  logic [2*tamano-1:0]    M_S;
  logic                   M_END;

  modport slave (
    input  REQ, A_BUS, B_BUS, M_S, M_END,
    output GNT, DONE, RESULT, ERR, BUSY, M_START, M_A, M_B
  );

  modport master (
    output REQ, A_BUS, B_BUS, M_S, M_END,
    input  GNT, DONE, RESULT, ERR, BUSY, M_START, M_A, M_B
  );

endinterface

// File: rtl/mult_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mult_rr_arbiter
//   Shares one START/END_MULT multiplier between NREQ requesters with
//   round-robin arbitration. The granted operands are registered onto M_A/M_B
//   and held until the product is captured; a one-cycle M_START launches the
//   multiplier, M_S is captured on M_END and returned on RESULT together with
//   a one-cycle DONE pulse on the owner's bit.
//
// Parameters
//   tamano   operand width (signed); RESULT is 2*tamano
//   NREQ     number of requesters (>= 2)
//   TIMEOUT  watchdog limit in S_WAIT cycles (only with MULT_TIMEOUT_EN)
//
// Ports
//   CLOCK    rising-edge clock
//   RESET    asynchronous active-low reset
//   bus      mult_rr_arbiter_if.slave (client and multiplier signals)
//
// Build option
//   `define MULT_TIMEOUT_EN  adds the S_WAIT watchdog: after TIMEOUT cycles
//   without M_END the operation ends with DONE[owner], ERR=1, RESULT=0.
//   Without it ERR is constant 0 and S_WAIT waits for M_END indefinitely.
//
// The attached multiplier must take at least two cycles; M_END seen outside
// S_WAIT is ignored.
// ----------------------------------------------------------------------------
module mult_rr_arbiter #(
  parameter int tamano  = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               CLOCK,
  input  logic               RESET,
  mult_rr_arbiter_if.slave   bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("mult_rr_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     ptr_q;      // last granted requester
  logic [IDXW-1:0]     owner_q;    // requester of the operation in flight
  logic [IDXW-1:0]     win_idx;
  logic                win_valid;
  logic                grant;
  logic                capture;
  logic                expire;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done_q;
  logic [2*tamano-1:0] result_q;
  logic [tamano-1:0]   m_a_q, m_b_q;

  // Round-robin search: first set REQ starting just after the last winner.
  always_comb begin
    int idx;
    // NOTE: every variable assigned here gets a value before any condition,
    // so no path leaves it holding its old value (which would infer a latch).
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!win_valid && bus.REQ[IDXW'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(idx);
      end
    end
  end

  // Next state and combinational outputs. GNT is gated by RESET so that a
  // requester is never told it was granted while the registers are held.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid && RESET) begin
          gnt[win_idx] = 1'b1;
          grant        = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.M_END) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (expire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is reset so that RESULT and
  // M_A/M_B read 0 after reset and an aborted operation leaves no trace.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDXW'(NREQ - 1);
      owner_q  <= '0;
      m_a_q    <= '0;
      m_b_q    <= '0;
      result_q <= '0;
      done_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register samples
      // pre-edge values, and the later done_q[owner_q] overrides the clear.
      state_q <= state_d;
      done_q  <= '0;
      if (grant) begin
        m_a_q   <= bus.A_BUS[win_idx*tamano +: tamano];
        m_b_q   <= bus.B_BUS[win_idx*tamano +: tamano];
        owner_q <= win_idx;
        ptr_q   <= win_idx;
      end
      if (capture) begin
        result_q        <= bus.M_S;
        done_q[owner_q] <= 1'b1;
      end else if (expire) begin
        result_q        <= '0;
        done_q[owner_q] <= 1'b1;
      end
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q;
  logic           err_q;

  // Counter sits at 0 outside S_WAIT, so it is fresh on every entry. It
  // never passes TIMEOUT-1 because expiry leaves S_WAIT.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= expire && !bus.M_END;
      if (state_q != S_WAIT) wd_q <= '0;
      else                   wd_q <= wd_q + 1'b1;
    end
  end

  assign expire  = (state_q == S_WAIT) && (wd_q == WDW'(TIMEOUT - 1));
  assign bus.ERR = err_q;
`else
  assign expire  = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  assign bus.GNT     = gnt;
  assign bus.DONE    = done_q;
  assign bus.RESULT  = result_q;
  assign bus.BUSY    = (state_q == S_START) || (state_q == S_WAIT);
  assign bus.M_START = (state_q == S_START);
  assign bus.M_A     = m_a_q;
  assign bus.M_B     = m_b_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mult_rr_arbiter
//   Bench for mult_rr_arbiter (tamano=8, NREQ=4, TIMEOUT=64) driving a
//   behavioural four-cycle START/END_MULT multiplier. Expected DONE/RESULT/ERR
//   entries are queued when stimulus is applied and compared by a monitor as
//   DONE pulses appear. Each scenario task also checks timing inline.
// ----------------------------------------------------------------------------
module tb_mult_rr_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int CYC = 4;

  logic CLOCK;
  logic RESET;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    int res;
    bit err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] mon_d;

  mult_rr_arbiter_if #(.tamano(W), .NREQ(N)) bif ();

  mult_rr_arbiter #(.tamano(W), .NREQ(N), .TIMEOUT(64)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bif.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Behavioural multiplier: END_MULT rises CYC cycles after the START cycle.
  logic [2:0]          mcnt;
  logic signed [W-1:0] ma, mb;
  logic signed [2*W-1:0] m_prod;
  bit stub_end  = 1'b0;
  bit stray_end = 1'b0;

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      mcnt <= '0;
      ma   <= '0;
      mb   <= '0;
    end else if (bif.M_START) begin
      mcnt <= 3'(CYC);
      ma   <= bif.M_A;
      mb   <= bif.M_B;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 3'd1;
    end
  end

  assign m_prod    = ma * mb;
  assign bif.M_END = stray_end || (!stub_end && mcnt == 3'd1);
  assign bif.M_S   = (mcnt == 3'd1) ? m_prod : 16'h5A5A;

  function automatic int mul(input int a, input int b);
    return a * b;
  endfunction

  // Scoreboard monitor.
  always @(negedge CLOCK) begin
    if (RESET === 1'b1 && bif.DONE !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done DONE=%b RESULT=%0d required no DONE",
                 bif.DONE, $signed(bif.RESULT));
      end else begin
        mon_e = sb.pop_front();
        mon_d = 4'b0001 << mon_e.idx;
        if (bif.DONE !== mon_d || $signed(bif.RESULT) !== mon_e.res ||
            bif.ERR !== mon_e.err) begin
          errors++;
          $display("FAIL sb_done DONE=%b RESULT=%0d ERR=%b required DONE=%b RESULT=%0d ERR=%b",
                   bif.DONE, $signed(bif.RESULT), bif.ERR, mon_d, mon_e.res, mon_e.err);
        end
      end
    end
  end

  // Protocol properties.
  a_gnt_onehot: assert property (@(posedge CLOCK) disable iff (!RESET) $onehot0(bif.GNT))
    else begin errors++; $display("FAIL assert_gnt_onehot GNT=%b required onehot0", bif.GNT); end
  a_done_onehot: assert property (@(posedge CLOCK) disable iff (!RESET) $onehot0(bif.DONE))
    else begin errors++; $display("FAIL assert_done_onehot DONE=%b required onehot0", bif.DONE); end
  a_start_pulse: assert property (@(posedge CLOCK) disable iff (!RESET) bif.M_START |=> !bif.M_START)
    else begin errors++; $display("FAIL assert_start_pulse M_START=1 required 0"); end
  a_ops_stable: assert property (@(posedge CLOCK) disable iff (!RESET)
                                 (bif.BUSY && $past(bif.BUSY)) |-> ($stable(bif.M_A) && $stable(bif.M_B)))
    else begin errors++; $display("FAIL assert_ops_stable M_A=%h M_B=%h required stable", bif.M_A, bif.M_B); end

  task automatic set_ops(input int idx, input int a, input int b);
    bif.A_BUS[idx*W +: W] = W'(a);
    bif.B_BUS[idx*W +: W] = W'(b);
  endtask

  task automatic push_exp(input int idx, input int res, input bit err);
    exp_t e;
    e.idx = idx;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  // Bounded wait for a grant, sampled on negedges; returns 0 on timeout.
  task automatic wait_gnt(output logic [N-1:0] g);
    int n;
    n = 0;
    @(negedge CLOCK);
    while (bif.GNT === '0 && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    g = bif.GNT;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge CLOCK);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
      sb.delete();
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_op(input string name, input int idx, input int a, input int b, input int res);
    logic [N-1:0] g, eg;
    @(posedge CLOCK);
    #1;
    set_ops(idx, a, b);
    bif.REQ[idx] = 1'b1;
    push_exp(idx, res, 1'b0);
    wait_gnt(g);
    eg = 4'b0001 << idx;
    checks++;
    if (g !== eg) begin
      errors++;
      $display("FAIL %s_gnt GNT=%b required %b", name, g, eg);
    end
    @(posedge CLOCK);
    #1;
    bif.REQ = '0;
    wait_drain(name);
  endtask

  task automatic test_reset;
    bif.REQ   = '1;
    bif.A_BUS = '0;
    bif.B_BUS = '0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    checks++; if (bif.GNT !== '0)     begin errors++; $display("FAIL reset_gnt GNT=%b required 0000", bif.GNT); end
    checks++; if (bif.DONE !== '0)    begin errors++; $display("FAIL reset_done DONE=%b required 0000", bif.DONE); end
    checks++; if (bif.RESULT !== '0)  begin errors++; $display("FAIL reset_result RESULT=%h required 0", bif.RESULT); end
    checks++; if (bif.ERR !== 1'b0)   begin errors++; $display("FAIL reset_err ERR=%b required 0", bif.ERR); end
    checks++; if (bif.BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy BUSY=%b required 0", bif.BUSY); end
    checks++; if (bif.M_START !== 1'b0) begin errors++; $display("FAIL reset_mstart M_START=%b required 0", bif.M_START); end
    checks++; if ({bif.M_A, bif.M_B} !== '0) begin errors++; $display("FAIL reset_ops M_A=%h M_B=%h required 0", bif.M_A, bif.M_B); end
    bif.REQ = '0;
    @(posedge CLOCK);
    #1 RESET = 1'b1;
    @(negedge CLOCK);
    checks++; if (bif.BUSY !== 1'b0 || bif.GNT !== '0) begin errors++; $display("FAIL idle_after_reset BUSY=%b GNT=%b required 0/0000", bif.BUSY, bif.GNT); end
  endtask

  // REQ=0001, 5*-3: GNT cycle 0, M_START cycle 1, DONE cycle 6.
  task automatic test_single;
    logic [N-1:0] g;
    int cyc;
    @(posedge CLOCK);
    #1;
    set_ops(0, 5, -3);
    bif.REQ = 4'b0001;
    push_exp(0, -15, 1'b0);
    @(negedge CLOCK);
    g = bif.GNT;
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt GNT=%b required 0001", g); end
    @(posedge CLOCK);
    #1 bif.REQ = '0;
    @(negedge CLOCK);
    cyc = 1;
    checks++; if (bif.M_START !== 1'b1) begin errors++; $display("FAIL single_mstart M_START=%b required 1", bif.M_START); end
    checks++; if (bif.M_A !== 8'h05 || bif.M_B !== 8'hFD) begin errors++; $display("FAIL single_ops M_A=%h M_B=%h required 05/fd", bif.M_A, bif.M_B); end
    while (bif.DONE === '0 && cyc < 40) begin
      @(negedge CLOCK);
      cyc++;
    end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL single_latency done_cycle=%0d required 6", cyc); end
    wait_drain("single");
  endtask

  task automatic test_corners;
    do_op("corner_mm", 3, -128, -128, 16384);
    do_op("corner_mp", 3, -128,  127, -16256);
    do_op("corner_zero", 3, 0, 77, 0);
  endtask

  // All four held from ptr=3: order 0,1,2,3,0 with DONE and next GNT together.
  task automatic test_fairness;
    int order [5] = '{0, 1, 2, 3, 0};
    int av [4] = '{3, -7, 100, -50};
    int bv [4] = '{11, 9, -2, -60};
    logic [N-1:0] eg;
    int grants, n;
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < N; i++) set_ops(i, av[i], bv[i]);
    bif.REQ = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(order[k], mul(av[order[k]], bv[order[k]]), 1'b0);
    grants = 0;
    n = 0;
    while (grants < 5 && n < 300) begin
      @(negedge CLOCK);
      n++;
      if (bif.GNT !== '0) begin
        eg = 4'b0001 << order[grants];
        checks++;
        if (bif.GNT !== eg) begin errors++; $display("FAIL fair_gnt%0d GNT=%b required %b", grants, bif.GNT, eg); end
        if (grants > 0) begin
          checks++;
          if (bif.DONE === '0) begin errors++; $display("FAIL fair_gap%0d DONE=%b required nonzero with GNT", grants, bif.DONE); end
        end
        grants++;
      end
    end
    checks++;
    if (grants != 5) begin errors++; $display("FAIL fair_count grants=%0d required 5", grants); end
    @(posedge CLOCK);
    #1 bif.REQ = '0;
    wait_drain("fair");
  endtask

  // ptr=3, REQ=1001: 0 wins by wrap-around, 3 stays pending and follows.
  task automatic test_wrap;
    logic [N-1:0] g;
    do_op("wrap_pre", 3, 12, 12, 144);
    @(posedge CLOCK);
    #1;
    set_ops(0, -1, 1);
    set_ops(3, 2, -2);
    bif.REQ = 4'b1001;
    push_exp(0, -1, 1'b0);
    push_exp(3, -4, 1'b0);
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 GNT=%b required 0001", g); end
    @(posedge CLOCK);
    #1 bif.REQ[0] = 1'b0;
    wait_gnt(g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3 GNT=%b required 1000", g); end
    @(posedge CLOCK);
    #1 bif.REQ = '0;
    wait_drain("wrap");
  endtask

  task automatic stray_pulse(input string name);
    @(posedge CLOCK);
    #1 stray_end = 1'b1;
    @(posedge CLOCK);
    #1 stray_end = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (bif.DONE !== '0 || bif.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s DONE=%b BUSY=%b required 0000/0", name, bif.DONE, bif.BUSY);
    end
  endtask

  task automatic test_stray_end;
    stray_pulse("stray_idle");
  endtask

  task automatic test_reset_mid_op;
    logic [N-1:0] g;
    @(posedge CLOCK);
    #1;
    set_ops(1, 9, 9);
    bif.REQ = 4'b0010;
    wait_gnt(g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL midrst_gnt GNT=%b required 0010", g); end
    @(posedge CLOCK);
    #1 bif.REQ = '0;
    repeat (3) @(posedge CLOCK);
    #2;
    checks++; if (bif.BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy BUSY=%b required 1", bif.BUSY); end
    RESET = 1'b0;
    #1;
    checks++;
    if ({bif.GNT, bif.DONE, bif.RESULT, bif.ERR, bif.BUSY, bif.M_START, bif.M_A, bif.M_B} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs GNT=%b DONE=%b RESULT=%h ERR=%b BUSY=%b M_START=%b M_A=%h M_B=%h required all 0",
               bif.GNT, bif.DONE, bif.RESULT, bif.ERR, bif.BUSY, bif.M_START, bif.M_A, bif.M_B);
    end
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b1;
    do_op("midrst_after", 2, 7, -9, -63);
  endtask

`ifdef MULT_TIMEOUT_EN
  // M_END stubbed: DONE/ERR 64 cycles after entering S_WAIT (cycle 2).
  task automatic test_timeout;
    logic [N-1:0] g;
    int cyc;
    stub_end = 1'b1;
    @(posedge CLOCK);
    #1;
    set_ops(1, 3, 4);
    bif.REQ = 4'b0010;
    push_exp(1, 0, 1'b1);
    @(negedge CLOCK);
    g = bif.GNT;
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL tmo_gnt GNT=%b required 0010", g); end
    @(posedge CLOCK);
    #1 bif.REQ = '0;
    @(negedge CLOCK);
    cyc = 1;
    while (bif.DONE === '0 && cyc < 200) begin
      @(negedge CLOCK);
      cyc++;
    end
    checks++; if (cyc !== 66) begin errors++; $display("FAIL tmo_latency done_cycle=%0d required 66", cyc); end
    wait_drain("tmo");
    stub_end = 1'b0;
    stray_pulse("tmo_stray");
  endtask
`endif

  initial begin
    bif.REQ   = '0;
    bif.A_BUS = '0;
    bif.B_BUS = '0;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_wrap();
    test_stray_end();
    test_reset_mid_op();
`ifdef MULT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge CLOCK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
